// File: rtl/match_cnt_param_if.sv
// rtl/match_cnt_param_if.sv - control/data/status bundle for match_cnt_param.
interface match_cnt_param_if #(
  parameter int HALF_W = 2,
  parameter int CNT_W  = 8
);
  logic                  start_i;
  logic                  stop_i;
  logic                  clr_i;
  logic [1:0]            mode_i;
  logic [CNT_W-1:0]      thresh_i;
  logic [2*HALF_W-1:0]   in1;
  logic                  match_o;
  logic [CNT_W-1:0]      equal_cnt;
  logic                  busy_o;
  logic                  done_o;
  logic                  hit_o;
  logic                  ovf_o;
  logic [CNT_W-1:0]      run_len_o;
  logic [CNT_W-1:0]      max_run_o;

  modport master (
    output start_i, stop_i, clr_i, mode_i, thresh_i, in1,
    input  match_o, equal_cnt, busy_o, done_o, hit_o, ovf_o, run_len_o, max_run_o
  );

  modport slave (
    input  start_i, stop_i, clr_i, mode_i, thresh_i, in1,
    output match_o, equal_cnt, busy_o, done_o, hit_o, ovf_o, run_len_o, max_run_o
  );
endinterface

// File: rtl/match_cnt_param.sv
// rtl/match_cnt_param.sv - half-compare match counter with threshold/done and overflow.
// Optional run-length statistics enabled by MATCH_CNT_RUNLEN_EN.
module match_cnt_param #(
  parameter int HALF_W   = 2,
  parameter int CNT_W    = 8,
  parameter int SATURATE = 0
) (
  input logic              clk_i,
  input logic              rst_ni,
  match_cnt_param_if.slave bus
);
  typedef enum logic [1:0] {S_IDLE, S_COUNT, S_DONE} state_t;

  localparam bit SAT = (SATURATE != 0);

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_hit;
  logic             r_ovf;

  logic [HALF_W-1:0] w_hi;
  logic [HALF_W-1:0] w_lo;
  logic              w_match;
  logic              w_cnt_max;
  logic [CNT_W-1:0]  w_cnt_inc;
  logic [CNT_W-1:0]  w_cnt_next;
  logic              w_thresh_hit;

  assign w_hi = bus.in1[2*HALF_W-1:HALF_W];
  assign w_lo = bus.in1[HALF_W-1:0];

  always_comb begin
    w_match = 1'b0;
    case (bus.mode_i)
      2'b00:   w_match = (w_hi == w_lo);
      2'b01:   w_match = (w_hi >  w_lo);
      2'b10:   w_match = (w_hi <  w_lo);
      default: w_match = (w_hi != w_lo);
    endcase
  end

  assign w_cnt_max  = &r_cnt;
  assign w_cnt_inc  = r_cnt + CNT_W'(1);
  assign w_cnt_next = (w_cnt_max && SAT) ? r_cnt : w_cnt_inc;
  // A saturated counter that does not move cannot re-fire the threshold.
  assign w_thresh_hit = w_match && (bus.thresh_i != '0) && !(w_cnt_max && SAT)
                        && (w_cnt_inc == bus.thresh_i);

`ifdef MATCH_CNT_RUNLEN_EN
  logic [CNT_W-1:0] r_run;
  logic [CNT_W-1:0] r_max;
  logic [CNT_W-1:0] w_run_next;
  logic [CNT_W-1:0] w_max_next;

  assign w_run_next = w_match ? ((&r_run) ? r_run : r_run + CNT_W'(1)) : '0;
  assign w_max_next = (w_run_next > r_max) ? w_run_next : r_max;
`endif

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_hit   <= 1'b0;
      r_ovf   <= 1'b0;
`ifdef MATCH_CNT_RUNLEN_EN
      r_run   <= '0;
      r_max   <= '0;
`endif
    end else begin
      r_hit <= 1'b0;
      if (bus.clr_i) begin
        r_state <= S_IDLE;
        r_cnt   <= '0;
        r_ovf   <= 1'b0;
`ifdef MATCH_CNT_RUNLEN_EN
        r_run   <= '0;
        r_max   <= '0;
`endif
      end else if (bus.stop_i) begin
        r_state <= S_IDLE;
      end else if (bus.start_i) begin
        // Restart from DONE begins a fresh measurement; resume from IDLE keeps totals.
        if (r_state == S_DONE) begin
          r_cnt <= '0;
          r_ovf <= 1'b0;
`ifdef MATCH_CNT_RUNLEN_EN
          r_run <= '0;
`endif
        end
        r_state <= S_COUNT;
      end else if (r_state == S_COUNT) begin
        if (w_match) begin
          r_cnt <= w_cnt_next;
          if (w_cnt_max) r_ovf <= 1'b1;
          if (w_thresh_hit) begin
            r_state <= S_DONE;
            r_hit   <= 1'b1;
          end
        end
`ifdef MATCH_CNT_RUNLEN_EN
        r_run <= w_run_next;
        r_max <= w_max_next;
`endif
      end
    end
  end

  assign bus.match_o   = w_match;
  assign bus.equal_cnt = r_cnt;
  assign bus.busy_o    = (r_state == S_COUNT);
  assign bus.done_o    = (r_state == S_DONE);
  assign bus.hit_o     = r_hit;
  assign bus.ovf_o     = r_ovf;
`ifdef MATCH_CNT_RUNLEN_EN
  assign bus.run_len_o = r_run;
  assign bus.max_run_o = r_max;
`else
  assign bus.run_len_o = '0;
  assign bus.max_run_o = '0;
`endif
endmodule

// File: tb/tb_match_cnt_param.sv
// tb/tb_match_cnt_param.sv - directed bench for match_cnt_param (8-bit, 4-bit wrap, 4-bit saturate).
module tb_match_cnt_param;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0, stop = 1'b0, clr = 1'b0;
  logic [1:0] mode = 2'b00;
  logic [7:0] thresh = 8'd0;
  logic [3:0] in1 = 4'b0000;
  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  match_cnt_param_if #(.HALF_W(2), .CNT_W(8)) if_a ();
  match_cnt_param_if #(.HALF_W(2), .CNT_W(4)) if_w ();
  match_cnt_param_if #(.HALF_W(2), .CNT_W(4)) if_s ();

  assign if_a.start_i = start;  assign if_w.start_i = start;  assign if_s.start_i = start;
  assign if_a.stop_i  = stop;   assign if_w.stop_i  = stop;   assign if_s.stop_i  = stop;
  assign if_a.clr_i   = clr;    assign if_w.clr_i   = clr;    assign if_s.clr_i   = clr;
  assign if_a.mode_i  = mode;   assign if_w.mode_i  = mode;   assign if_s.mode_i  = mode;
  assign if_a.in1     = in1;    assign if_w.in1     = in1;    assign if_s.in1     = in1;
  assign if_a.thresh_i = thresh;
  assign if_w.thresh_i = thresh[3:0];
  assign if_s.thresh_i = thresh[3:0];

  match_cnt_param #(.HALF_W(2), .CNT_W(8), .SATURATE(0)) u_a (.clk_i(clk), .rst_ni(rst_n), .bus(if_a));
  match_cnt_param #(.HALF_W(2), .CNT_W(4), .SATURATE(0)) u_w (.clk_i(clk), .rst_ni(rst_n), .bus(if_w));
  match_cnt_param #(.HALF_W(2), .CNT_W(4), .SATURATE(1)) u_s (.clk_i(clk), .rst_ni(rst_n), .bus(if_s));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    start = 1'($urandom); stop = 1'($urandom); clr = 1'($urandom);
    mode = 2'($urandom); in1 = 4'($urandom); thresh = 8'($urandom);
    tick(); tick();
    n_vec++; if (if_a.equal_cnt !== 8'd0) begin n_bad++; $display("FAIL rst_cnt got %0d want 0", if_a.equal_cnt); end
    n_vec++; if ({if_a.busy_o, if_a.done_o, if_a.hit_o, if_a.ovf_o} !== 4'b0000) begin n_bad++; $display("FAIL rst_flags got %b want 0000", {if_a.busy_o, if_a.done_o, if_a.hit_o, if_a.ovf_o}); end
    n_vec++; if ({if_a.run_len_o, if_a.max_run_o} !== 16'd0) begin n_bad++; $display("FAIL rst_run got %h want 0", {if_a.run_len_o, if_a.max_run_o}); end
    n_vec++; if ({if_w.equal_cnt, if_s.equal_cnt} !== 8'd0) begin n_bad++; $display("FAIL rst_small got %h want 0", {if_w.equal_cnt, if_s.equal_cnt}); end
    rst_n = 1'b1; start = 0; stop = 0; clr = 0; mode = 2'b00; in1 = 4'b0000; thresh = 8'd0;
    tick(); tick(); tick();
    n_vec++; if ({if_a.equal_cnt, if_a.busy_o} !== 9'd0) begin n_bad++; $display("FAIL idle_nocount got cnt=%0d busy=%b want 0/0", if_a.equal_cnt, if_a.busy_o); end
  endtask

  task automatic test_count();
    logic [3:0] pat [4] = '{4'b0101, 4'b1001, 4'b1111, 4'b0100};
    logic [7:0] exp [4] = '{8'd1, 8'd1, 8'd2, 8'd2};
    start = 1; tick(); start = 0;
    n_vec++; if ({if_a.busy_o, if_a.equal_cnt} !== {1'b1, 8'd0}) begin n_bad++; $display("FAIL start_cycle got busy=%b cnt=%0d want 1/0", if_a.busy_o, if_a.equal_cnt); end
    for (int i = 0; i < 4; i++) begin
      in1 = pat[i]; tick();
      n_vec++; if (if_a.equal_cnt !== exp[i]) begin n_bad++; $display("FAIL count[%0d] got %0d want %0d", i, if_a.equal_cnt, exp[i]); end
    end
    in1 = 4'b0000; stop = 1; tick(); stop = 0;
    for (int i = 0; i < 5; i++) tick();
    n_vec++; if ({if_a.busy_o, if_a.equal_cnt} !== {1'b0, 8'd2}) begin n_bad++; $display("FAIL stopped got busy=%b cnt=%0d want 0/2", if_a.busy_o, if_a.equal_cnt); end
    start = 1; tick(); start = 0;
    n_vec++; if (if_a.equal_cnt !== 8'd2) begin n_bad++; $display("FAIL resume_start got %0d want 2", if_a.equal_cnt); end
    tick();
    n_vec++; if (if_a.equal_cnt !== 8'd3) begin n_bad++; $display("FAIL resume got %0d want 3", if_a.equal_cnt); end
  endtask

  task automatic test_threshold();
    logic [7:0] exp_cnt [5] = '{8'd1, 8'd2, 8'd3, 8'd3, 8'd3};
    logic       exp_hit [5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    logic       exp_done[5] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    clr = 1; tick(); clr = 0;
    n_vec++; if ({if_a.busy_o, if_a.equal_cnt} !== 9'd0) begin n_bad++; $display("FAIL clr got busy=%b cnt=%0d want 0/0", if_a.busy_o, if_a.equal_cnt); end
    thresh = 8'd3; mode = 2'b00; in1 = 4'b0000;
    start = 1; tick(); start = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      n_vec++;
      if ({if_a.equal_cnt, if_a.hit_o, if_a.done_o} !== {exp_cnt[i], exp_hit[i], exp_done[i]}) begin
        n_bad++;
        $display("FAIL thresh[%0d] got cnt=%0d hit=%b done=%b want %0d/%b/%b", i, if_a.equal_cnt, if_a.hit_o, if_a.done_o, exp_cnt[i], exp_hit[i], exp_done[i]);
      end
    end
    start = 1; tick(); start = 0;
    n_vec++; if ({if_a.equal_cnt, if_a.busy_o, if_a.done_o, if_a.hit_o} !== {8'd0, 3'b100}) begin n_bad++; $display("FAIL restart got cnt=%0d busy=%b done=%b hit=%b want 0/1/0/0", if_a.equal_cnt, if_a.busy_o, if_a.done_o, if_a.hit_o); end
    clr = 1; thresh = 8'd0; tick(); clr = 0;
  endtask

  task automatic test_overflow();
    mode = 2'b00; in1 = 4'b0000;
    start = 1; tick(); start = 0;
    for (int i = 0; i < 15; i++) tick();
    n_vec++; if ({if_w.equal_cnt, if_w.ovf_o} !== {4'd15, 1'b0}) begin n_bad++; $display("FAIL wrap_pre got cnt=%0d ovf=%b want 15/0", if_w.equal_cnt, if_w.ovf_o); end
    tick();
    n_vec++; if ({if_w.equal_cnt, if_w.ovf_o} !== {4'd0, 1'b1}) begin n_bad++; $display("FAIL wrap got cnt=%0d ovf=%b want 0/1", if_w.equal_cnt, if_w.ovf_o); end
    n_vec++; if ({if_s.equal_cnt, if_s.ovf_o} !== {4'd15, 1'b1}) begin n_bad++; $display("FAIL sat got cnt=%0d ovf=%b want 15/1", if_s.equal_cnt, if_s.ovf_o); end
    n_vec++; if ({if_a.equal_cnt, if_a.ovf_o} !== {8'd16, 1'b0}) begin n_bad++; $display("FAIL wide16 got cnt=%0d ovf=%b want 16/0", if_a.equal_cnt, if_a.ovf_o); end
    tick();
    n_vec++; if ({if_w.equal_cnt, if_w.ovf_o, if_s.equal_cnt} !== {4'd1, 1'b1, 4'd15}) begin n_bad++; $display("FAIL post_ovf got w=%0d ovf=%b s=%0d want 1/1/15", if_w.equal_cnt, if_w.ovf_o, if_s.equal_cnt); end
    clr = 1; tick(); clr = 0;
    n_vec++; if ({if_w.equal_cnt, if_w.ovf_o, if_s.equal_cnt, if_s.ovf_o} !== 10'd0) begin n_bad++; $display("FAIL ovf_clr got w=%0d/%b s=%0d/%b want 0", if_w.equal_cnt, if_w.ovf_o, if_s.equal_cnt, if_s.ovf_o); end
  endtask

  task automatic test_modes();
    logic [1:0] m   [5] = '{2'b01, 2'b01, 2'b10, 2'b11, 2'b11};
    logic [3:0] d   [5] = '{4'b1001, 4'b0110, 4'b0110, 4'b1010, 4'b1110};
    logic       em  [5] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    logic [7:0] ec  [5] = '{8'd1, 8'd1, 8'd2, 8'd2, 8'd3};
    start = 1; tick(); start = 0;
    for (int i = 0; i < 5; i++) begin
      mode = m[i]; in1 = d[i]; #1;
      n_vec++; if (if_a.match_o !== em[i]) begin n_bad++; $display("FAIL match[%0d] got %b want %b", i, if_a.match_o, em[i]); end
      tick();
      n_vec++; if (if_a.equal_cnt !== ec[i]) begin n_bad++; $display("FAIL mode_cnt[%0d] got %0d want %0d", i, if_a.equal_cnt, ec[i]); end
    end
    clr = 1; tick(); clr = 0;
  endtask

  task automatic test_runlen();
    logic [3:0] d  [6] = '{4'b0000, 4'b0101, 4'b1111, 4'b0100, 4'b1010, 4'b0000};
    logic [7:0] er [6] = '{8'd1, 8'd2, 8'd3, 8'd0, 8'd1, 8'd2};
    logic [7:0] em [6] = '{8'd1, 8'd2, 8'd3, 8'd3, 8'd3, 8'd3};
    mode = 2'b00;
    start = 1; tick(); start = 0;
    for (int i = 0; i < 6; i++) begin
      in1 = d[i]; tick();
`ifdef MATCH_CNT_RUNLEN_EN
      n_vec++; if ({if_a.run_len_o, if_a.max_run_o} !== {er[i], em[i]}) begin n_bad++; $display("FAIL run[%0d] got %0d/%0d want %0d/%0d", i, if_a.run_len_o, if_a.max_run_o, er[i], em[i]); end
`else
      n_vec++; if ({if_a.run_len_o, if_a.max_run_o} !== 16'd0) begin n_bad++; $display("FAIL run_off[%0d] got %0d/%0d want 0/0 (steps %0d/%0d)", i, if_a.run_len_o, if_a.max_run_o, er[i], em[i]); end
`endif
    end
    clr = 1; tick(); clr = 0;
    n_vec++; if ({if_a.run_len_o, if_a.max_run_o, if_a.equal_cnt, if_a.busy_o} !== 25'd0) begin n_bad++; $display("FAIL run_clr got run=%0d max=%0d cnt=%0d busy=%b want 0", if_a.run_len_o, if_a.max_run_o, if_a.equal_cnt, if_a.busy_o); end
  endtask

  initial begin
    test_reset();
    test_count();
    test_threshold();
    test_overflow();
    test_modes();
    test_runlen();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule

// File: doc/match_cnt_param.md
Name: match_cnt_param

Overview:
- Parametrised successor of the half-compare equality counter.
- Splits `in1` into high/low halves of HALF_W bits and compares them under a runtime-selectable mode. While armed, it counts cycles on which the comparison holds.
- Adds start/stop/clear control, wrap or saturate overflow, a programmable threshold with done state, and optional run-length statistics.
- Sits beside datapath monitors as a generic event/statistics counter.

Parameters:
- HALF_W, 2: width of each half of `in1`; `in1` is 2*HALF_W bits.
- CNT_W, 8: width of `equal_cnt`, `thresh_i`, `run_len_o`, `max_run_o`.
- SATURATE, 0: 0 = `equal_cnt` wraps at overflow; 1 = `equal_cnt` holds at all-ones.

Ports:
- clk_i  in  1  single clock; all state on rising edge.
- rst_ni  in  1  reset, synchronous, active-low.
- start_i  in  1  arm counting.
- stop_i  in  1  disarm, keep values.
- clr_i  in  1  synchronous clear of all counters/flags.
- mode_i  in  2  00 high==low, 01 high>low, 10 high<low, 11 high!=low (unsigned).
- thresh_i  in  CNT_W  threshold; 0 = disabled.
- in1  in  2*HALF_W  data; high = in1[2*HALF_W-1:HALF_W], low = in1[HALF_W-1:0].
- match_o  out  1  combinational compare result of current in1/mode_i.
- equal_cnt  out  CNT_W  match count.
- busy_o  out  1  state==COUNT.
- done_o  out  1  state==DONE.
- hit_o  out  1  one-cycle pulse on threshold reached.
- ovf_o  out  1  sticky overflow flag.
- run_len_o  out  CNT_W  current consecutive-match run.
- max_run_o  out  CNT_W  longest run since clear.

Behaviour:
- Reset (rst_ni=0 at rising edge):
  - state=IDLE.
  - `equal_cnt`, `run_len_o`, `max_run_o`, `ovf_o`, `hit_o` = 0.
  - `busy_o` = `done_o` = 0.
- `match_o` is independent of state; it is the only combinational output. All others are registered.
- Priority per edge: reset > clr_i > stop_i > start_i > counting.
- FSM states: IDLE, COUNT, DONE.
  - IDLE: start_i -> COUNT, counters retained (resume). Nothing counted in IDLE.
  - COUNT: stop_i -> IDLE. Threshold hit -> DONE. Otherwise stay.
  - DONE: counters frozen. start_i -> COUNT and clears `equal_cnt`, `run_len_o`, `ovf_o`; `max_run_o` retained. stop_i -> IDLE.
  - clr_i in any state -> IDLE; zeroes all counters, `ovf_o`, `hit_o`.
- Counting, in COUNT only, when the cycle sees no stop_i/clr_i:
  - The cycle in which start_i is sampled is not counted; counting begins on the following edge.
  - match_o=1: equal_cnt <= equal_cnt+1.
  - At all-ones: SATURATE=0 wraps to 0; SATURATE=1 holds all-ones. Either way `ovf_o` <= 1 (sticky until clr_i or restart from DONE).
- Threshold:
  - Applies when thresh_i!=0 and the incremented value equals thresh_i.
  - On that edge: state -> DONE and hit_o <= 1 for exactly one cycle, aligned with `equal_cnt` first showing thresh_i.
  - thresh_i changing mid-run takes effect immediately. A value already passed is not hit again until wrap.
- `hit_o` is 0 in every cycle not described above.

Optional Feature:
- Macro: MATCH_CNT_RUNLEN_EN.
- Defined, in COUNT:
  - match -> run_len_o saturating +1; no match -> run_len_o <= 0.
  - max_run_o <= max(max_run_o, new run_len_o), same edge.
  - stop_i/IDLE holds both values.
- Undefined: `run_len_o` and `max_run_o` are tied to 0 and no run-length registers are inferred. Ports remain.

Test Plan (HALF_W=2, CNT_W=8 unless stated):
1. Hold rst_ni=0 two edges with random inputs -> all registered outputs 0, busy_o=done_o=0. Release; no start_i -> equal_cnt stays 0 despite in1=4'b0000.
2. mode_i=00, start_i one cycle, then in1=0101,1001,1111,0100 -> equal_cnt 1,1,2,2. Pulse stop_i, then 5 matching cycles -> stays 2. start_i again, one match -> 3.
3. thresh_i=3, mode 00, in1=0000 constant, start -> equal_cnt 1,2,3. hit_o=1 only in the cycle showing 3; done_o=1; further matches leave 3. start_i -> equal_cnt 0, busy_o=1.
4. CNT_W=4, SATURATE=0, 16 matches -> equal_cnt 15 then 0, ovf_o=1. SATURATE=1 -> holds 15, ovf_o=1. clr_i -> both 0.
5. mode_i=01: 1001 -> match_o=1; 0110 -> 0. mode_i=10: 0110 -> 1. mode_i=11: 1010 -> 0. Counts follow match_o.
6. With MATCH_CNT_RUNLEN_EN, mode 00: 3 matches, 1 miss, 2 matches -> run_len_o 1,2,3,0,1,2; max_run_o=3. clr_i mid-run -> all 0, IDLE. Without the macro -> both always 0.
